// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system bus bridge: address map, FSM states, target indices.
package sys_bus_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned NUM_TGT = 4;

    // Region bounds, inclusive
    localparam logic [ADDR_W-1:0] DM_START  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DM_END    = 32'h0000_2fff;
    localparam logic [ADDR_W-1:0] TC0_START = 32'h0000_7f00;
    localparam logic [ADDR_W-1:0] TC0_END   = 32'h0000_7f0b;
    localparam logic [ADDR_W-1:0] TC1_START = 32'h0000_7f10;
    localparam logic [ADDR_W-1:0] TC1_END   = 32'h0000_7f1b;
    localparam logic [ADDR_W-1:0] INT_START = 32'h0000_7f20;
    localparam logic [ADDR_W-1:0] INT_END   = 32'h0000_7f23;

    // Timer count registers are read-only
    localparam logic [ADDR_W-1:0] TC0_CNT_START = 32'h0000_7f08;
    localparam logic [ADDR_W-1:0] TC0_CNT_END   = 32'h0000_7f0b;
    localparam logic [ADDR_W-1:0] TC1_CNT_START = 32'h0000_7f18;
    localparam logic [ADDR_W-1:0] TC1_CNT_END   = 32'h0000_7f1b;

    // Target indices into the one-hot request vector
    localparam int unsigned TGT_DM  = 0;
    localparam int unsigned TGT_TC0 = 1;
    localparam int unsigned TGT_TC1 = 2;
    localparam int unsigned TGT_INT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latched request payload presented to the targets
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   byteen;
    } bus_req_t;

    // Inclusive range check; wraps below lo so a single compare suffices
    function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

endpackage

// File: rtl/sys_addr_decode.sv
// Combinational address decode: one-hot target select plus decode error.
module sys_addr_decode
    import sys_bus_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [BE_W-1:0]    byteen_i,
    output logic [NUM_TGT-1:0] tgt_onehot_o,
    output logic               dec_err_o
);

    logic [NUM_TGT-1:0] hit;
    logic               periph_hit;
    logic               cnt_hit;
    logic               is_store;
    logic               word_or_load;

    // Region match and access legality
    always_comb begin
        hit               = '0;
        hit[TGT_DM]       = in_range(addr_i, DM_START,  DM_END);
        hit[TGT_TC0]      = in_range(addr_i, TC0_START, TC0_END);
        hit[TGT_TC1]      = in_range(addr_i, TC1_START, TC1_END);
        hit[TGT_INT]      = in_range(addr_i, INT_START, INT_END);
        periph_hit        = hit[TGT_TC0] | hit[TGT_TC1] | hit[TGT_INT];
        cnt_hit           = in_range(addr_i, TC0_CNT_START, TC0_CNT_END)
                          | in_range(addr_i, TC1_CNT_START, TC1_CNT_END);
        is_store          = |byteen_i;
        word_or_load      = (byteen_i == 4'b0000) || (byteen_i == 4'b1111);
        dec_err_o         = ~(|hit)
                          | (periph_hit & ~word_or_load)
                          | (is_store & cnt_hit);
        tgt_onehot_o      = dec_err_o ? '0 : hit;
    end

endmodule

// File: rtl/sys_bus_bridge.sv
// Bridge from the M-stage data port to the system bus targets: one access at a time,
// holds the target request until ack or timeout, returns a one-cycle response.
module sys_bus_bridge
    import sys_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [BE_W-1:0]     req_byteen,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                stall,
    output logic [NUM_TGT-1:0]  tgt_req,
    output logic [ADDR_W-1:0]   tgt_addr,
    output logic [DATA_W-1:0]   tgt_wdata,
    output logic [BE_W-1:0]     tgt_byteen,
    input  logic [NUM_TGT-1:0]  tgt_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    input  logic [DATA_W-1:0]   tc0_rdata,
    input  logic [DATA_W-1:0]   tc1_rdata,
    input  logic [DATA_W-1:0]   int_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q,      state_d;
    bus_req_t           req_q,        req_d;
    logic [NUM_TGT-1:0] tgt_req_q,    tgt_req_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic               resp_err_q,   resp_err_d;

    logic [NUM_TGT-1:0] dec_onehot;
    logic               dec_err;
    logic               sel_ack;
    logic [DATA_W-1:0]  sel_rdata;

    sys_addr_decode u_dec (
        .addr_i       (req_addr),
        .byteen_i     (req_byteen),
        .tgt_onehot_o (dec_onehot),
        .dec_err_o    (dec_err)
    );

    // Only the selected target's ack and read data are honoured
    always_comb begin
        sel_ack   = |(tgt_ack & tgt_req_q);
        sel_rdata = ({DATA_W{tgt_req_q[TGT_DM]}}  & dm_rdata)
                  | ({DATA_W{tgt_req_q[TGT_TC0]}} & tc0_rdata)
                  | ({DATA_W{tgt_req_q[TGT_TC1]}} & tc1_rdata)
                  | ({DATA_W{tgt_req_q[TGT_INT]}} & int_rdata);
    end

    // Next-state and registered-output logic; response fields default to zero each cycle
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        tgt_req_d    = tgt_req_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{addr: req_addr, wdata: req_wdata, byteen: req_byteen};
                    if (dec_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else begin
                        tgt_req_d = dec_onehot;
                        cnt_d     = '0;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (sel_ack) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = (req_q.byteen == '0) ? sel_rdata : '0;
                    tgt_req_d    = '0;
                    state_d      = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    tgt_req_d    = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                tgt_req_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, request latch, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            tgt_req_q    <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            tgt_req_q    <= tgt_req_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Output mapping; stall follows the incoming request while idle
    always_comb begin
        req_ready  = (state_q == IDLE);
        stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
        tgt_req    = tgt_req_q;
        tgt_addr   = req_q.addr;
        tgt_wdata  = req_q.wdata;
        tgt_byteen = req_q.byteen;
    end

endmodule
